// File: rtl/ysyx_23060208_ifu_fetch_pkg.sv
// Shared definitions for the IFU fetch slice: IDU bus width, FSM and PC-select
// encodings, AXI response code and the default reset PC.
package ysyx_23060208_ifu_fetch_pkg;

  localparam int          IFU_TO_IDU_BUS   = 64;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [1:0]  RRESP_OKAY       = 2'b00;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_AR = 2'd1,
    FETCH_R  = 2'd2,
    SEND     = 2'd3
  } ifu_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/ysyx_23060208_ifu_pc.sv
// PC register for the fetch unit: holds, steps by 4 (wrapping) or takes a redirect
// target according to the select input; pc_nxt is the value loaded at the next edge.
module ysyx_23060208_ifu_pc
  import ysyx_23060208_ifu_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  pc_sel_e               sel,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_nxt
);

  always_comb begin
    pc_nxt = pc;
    unique case (sel)
      PC_HOLD:     pc_nxt = pc;
      PC_INC:      pc_nxt = pc + DATA_WIDTH'(4);
      PC_REDIRECT: pc_nxt = redirect_pc;
      default:     pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_nxt;
  end

endmodule

// File: rtl/ysyx_23060208_ifu_fetch.sv
// Instruction fetch unit: one AXI4-Lite read per instruction, {pc, inst} handed to
// the IDU under valid/allowin. Optional perf counters when IFU_PERF_CNT_EN is defined.
module ysyx_23060208_ifu_fetch
  import ysyx_23060208_ifu_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      redirect_valid,
  input  logic [DATA_WIDTH-1:0]     redirect_pc,
  output logic [DATA_WIDTH-1:0]     ifu_araddr,
  output logic                      ifu_arvalid,
  input  logic                      ifu_arready,
  input  logic [DATA_WIDTH-1:0]     ifu_rdata,
  input  logic [1:0]                ifu_rresp,
  input  logic                      ifu_rvalid,
  output logic                      ifu_rready,
  output logic [IFU_TO_IDU_BUS-1:0] ifu_to_idu_bus,
  output logic                      ifu_to_idu_valid,
  input  logic                      idu_allowin
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]               perf_fetch_cnt,
  output logic [31:0]               perf_stall_cnt
`endif
);

  function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] a);
    return {a[DATA_WIDTH-1:2], 2'b00};
  endfunction

  ifu_state_e                state;
  logic                      drop;
  logic [DATA_WIDTH-1:0]     araddr_q;
  logic [IFU_TO_IDU_BUS-1:0] bus_q;
  logic [DATA_WIDTH-1:0]     pc;
  logic [DATA_WIDTH-1:0]     pc_nxt;
  pc_sel_e                   pc_sel;
  logic                      ar_hs;
  logic                      xfer;

  assign ar_hs = (state == FETCH_AR) && ifu_arready;
  assign xfer  = (state == SEND) && idu_allowin;

  // A redirect always wins, even over a completing transfer in SEND.
  always_comb begin
    pc_sel = PC_HOLD;
    if (redirect_valid) pc_sel = PC_REDIRECT;
    else if (xfer)      pc_sel = PC_INC;
  end

  ysyx_23060208_ifu_pc #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (pc_sel),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_nxt      (pc_nxt)
  );

  // araddr is captured on entry to FETCH_AR so a redirect cannot move it mid-request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      drop     <= 1'b0;
      araddr_q <= word_align(RESET_PC);
      bus_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= FETCH_AR;
          araddr_q <= word_align(pc_nxt);
        end
        FETCH_AR: begin
          if (redirect_valid) drop  <= 1'b1;
          if (ar_hs)          state <= FETCH_R;
        end
        FETCH_R: begin
          if (ifu_rvalid) begin
            if (drop || redirect_valid) begin
              drop     <= 1'b0;
              state    <= FETCH_AR;
              araddr_q <= word_align(pc_nxt);
            end else begin
              bus_q <= {pc, (ifu_rresp == RRESP_OKAY) ? ifu_rdata : '0};
              state <= SEND;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        SEND: begin
          if (idu_allowin || redirect_valid) begin
            state    <= FETCH_AR;
            araddr_q <= word_align(pc_nxt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ifu_arvalid      = (state == FETCH_AR);
  assign ifu_rready       = (state == FETCH_R);
  assign ifu_to_idu_valid = (state == SEND);
  assign ifu_araddr       = araddr_q;
  assign ifu_to_idu_bus   = bus_q;

`ifdef IFU_PERF_CNT_EN
  logic stall;

  assign stall = ((state == FETCH_AR) && !ifu_arready) ||
                 ((state == FETCH_R)  && !ifu_rvalid)  ||
                 ((state == SEND)     && !idu_allowin);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (xfer)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
// Bench for ysyx_23060208_ifu_fetch: scripted cycle table, corner sequences and a
// randomized run against an AXI slave and an in-order delivery model.
module tb_ysyx_23060208_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [63:0] ifu_to_idu_bus;
  logic        ifu_to_idu_valid;
  logic        idu_allowin;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  ysyx_23060208_ifu_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .ifu_araddr       (ifu_araddr),
    .ifu_arvalid      (ifu_arvalid),
    .ifu_arready      (ifu_arready),
    .ifu_rdata        (ifu_rdata),
    .ifu_rresp        (ifu_rresp),
    .ifu_rvalid       (ifu_rvalid),
    .ifu_rready       (ifu_rready),
    .ifu_to_idu_bus   (ifu_to_idu_bus),
    .ifu_to_idu_valid (ifu_to_idu_valid),
    .idu_allowin      (idu_allowin)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory image and error map seen through the AXI slave.
  logic [31:0] err_pc   = 32'h8000_0004;
  bit          rand_err = 1'b0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic bit bad(input logic [31:0] a);
    return (a == err_pc) || (rand_err && (a[5:2] == 4'hb));
  endfunction

  // AXI slave state
  logic [31:0] q[$];
  int          rdly     = 0;
  int          rdly_max = 0;
  bit          ar_rand  = 1'b0;
  bit          r_rand   = 1'b0;
  bit          p_arv = 0, p_ard = 0, p_rv = 0, p_rr = 0;
  logic [31:0] p_addr = '0;

  // Called once per negedge: settle the handshakes of the edge just passed, drive next.
  task automatic slave_step();
    if (p_arv && !p_ard) begin
      chk("ar_kept_valid", ifu_arvalid, 1'b1);
      chk("ar_kept_addr", ifu_araddr, p_addr);
    end
    if (p_arv && p_ard) begin
      q.push_back(p_addr);
      rdly = r_rand ? $urandom_range(0, rdly_max) : rdly_max;
    end
    if (p_rv && p_rr) begin
      if (q.size() > 0) q.delete(0);
      ifu_rvalid = 1'b0;
    end
    if (!ifu_rvalid) begin
      if (q.size() > 0 && rdly == 0) begin
        ifu_rvalid = 1'b1;
        ifu_rdata  = mem(q[0]);
        ifu_rresp  = bad(q[0]) ? 2'b10 : 2'b00;
      end else begin
        if (q.size() > 0) rdly--;
        ifu_rdata = $urandom;
        ifu_rresp = 2'b00;
      end
    end
    ifu_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    p_arv = ifu_arvalid; p_ard = ifu_arready; p_addr = ifu_araddr;
    p_rv = ifu_rvalid;   p_rr = ifu_rready;
  endtask

  task automatic slave_flush();
    q.delete();
    rdly = 0;
    ifu_rvalid  = 1'b0;
    ifu_arready = 1'b1;
    p_arv = ifu_arvalid; p_ard = 1'b1; p_addr = ifu_araddr;
    p_rv = 1'b0;         p_rr = ifu_rready;
  endtask

  // Delivery model: instructions leave in address order from the current target,
  // a redirect replaces the next pc after any transfer of the same cycle.
  logic [31:0] exp_pc = RST_PC;
  int xfer_m = 0, stall_m = 0, xfer_b = 0, stall_b = 0;

  task automatic model_step();
    if (ifu_to_idu_valid && idu_allowin) begin
      chk("xfer_bus", ifu_to_idu_bus, {exp_pc, bad(exp_pc) ? 32'h0 : mem(exp_pc)});
      exp_pc = exp_pc + 32'd4;
      xfer_m++;
    end
    if (redirect_valid) exp_pc = redirect_pc;
    if ((ifu_arvalid && !ifu_arready) || (ifu_rready && !ifu_rvalid) ||
        (ifu_to_idu_valid && !idu_allowin)) stall_m++;
  endtask

  task automatic tick(input bit alw, input bit rd, input logic [31:0] rpc);
    @(negedge clk);
    xfer_b  = xfer_m;
    stall_b = stall_m;
    slave_step();
    idu_allowin    = alw;
    redirect_valid = rd;
    redirect_pc    = rpc;
    model_step();
  endtask

  typedef struct {
    bit          alw;
    bit          rd;
    logic [31:0] rpc;
    bit          arv;
    bit          rr;
    bit          v;
    logic [31:0] addr;
    logic [31:0] bpc;
    logic [31:0] binst;
  } vec_t;

  function automatic vec_t mk(bit alw, bit rd, logic [31:0] rpc, bit arv, bit rr, bit v,
                              logic [31:0] addr, logic [31:0] bpc, logic [31:0] binst);
    vec_t r;
    r.alw = alw; r.rd = rd; r.rpc = rpc; r.arv = arv; r.rr = rr; r.v = v;
    r.addr = addr; r.bpc = bpc; r.binst = binst;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int   n;

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; idu_allowin = 1'b0;
    ifu_arready = 1'b0; ifu_rdata = '0; ifu_rresp = 2'b00; ifu_rvalid = 1'b0;

    // lockstep slave: arready=1, rvalid the cycle after the AR handshake
    tbl.push_back(mk(1,0,0, 1,0,0, 32'h8000_0000, 0, 0));
    tbl.push_back(mk(1,0,0, 0,1,0, 0, 0, 0));
    tbl.push_back(mk(1,0,0, 0,0,1, 0, 32'h8000_0000, mem(32'h8000_0000)));
    tbl.push_back(mk(1,0,0, 1,0,0, 32'h8000_0004, 0, 0));
    tbl.push_back(mk(1,0,0, 0,1,0, 0, 0, 0));
    tbl.push_back(mk(1,0,0, 0,0,1, 0, 32'h8000_0004, 32'h0000_0000));
    tbl.push_back(mk(1,0,0, 1,0,0, 32'h8000_0008, 0, 0));
    tbl.push_back(mk(1,0,0, 0,1,0, 0, 0, 0));
    tbl.push_back(mk(1,0,0, 0,0,1, 0, 32'h8000_0008, mem(32'h8000_0008)));
    tbl.push_back(mk(1,0,0, 1,0,0, 32'h8000_000C, 0, 0));
    tbl.push_back(mk(1,0,0, 0,1,0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,0, 0,0,1, 0, 32'h8000_000C, mem(32'h8000_000C)));
    tbl.push_back(mk(1,0,0, 0,0,1, 0, 32'h8000_000C, mem(32'h8000_000C)));
    tbl.push_back(mk(1,0,0, 1,0,0, 32'h8000_0010, 0, 0));
    tbl.push_back(mk(1,1,32'h8000_0100, 0,1,0, 0, 0, 0));
    tbl.push_back(mk(1,0,0, 1,0,0, 32'h8000_0100, 0, 0));
    tbl.push_back(mk(1,0,0, 0,1,0, 0, 0, 0));
    tbl.push_back(mk(1,1,32'h8000_0200, 0,0,1, 0, 32'h8000_0100, mem(32'h8000_0100)));
    tbl.push_back(mk(1,0,0, 1,0,0, 32'h8000_0200, 0, 0));
    tbl.push_back(mk(1,0,0, 0,1,0, 0, 0, 0));
    tbl.push_back(mk(1,0,0, 0,0,1, 0, 32'h8000_0200, mem(32'h8000_0200)));
    tbl.push_back(mk(1,0,0, 1,0,0, 32'h8000_0204, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_arvalid", ifu_arvalid, 1'b0);
    chk("reset_rready", ifu_rready, 1'b0);
    chk("reset_valid", ifu_to_idu_valid, 1'b0);
    chk("reset_bus", ifu_to_idu_bus, 64'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      tick(tbl[i].alw, tbl[i].rd, tbl[i].rpc);
      chk($sformatf("row%0d_arvalid", i), ifu_arvalid, tbl[i].arv);
      chk($sformatf("row%0d_rready", i), ifu_rready, tbl[i].rr);
      chk($sformatf("row%0d_valid", i), ifu_to_idu_valid, tbl[i].v);
      if (tbl[i].arv) chk($sformatf("row%0d_araddr", i), ifu_araddr, tbl[i].addr);
      if (tbl[i].v)   chk($sformatf("row%0d_bus", i), ifu_to_idu_bus, {tbl[i].bpc, tbl[i].binst});
    end

    // async reset in FETCH_R, stale rvalid afterwards
    tick(1, 0, 0);
    chk("t6_in_fetch_r", ifu_rready, 1'b1);
    #2;
    rst_n = 1'b0;
    ifu_arready = 1'b0;
    #1;
    chk("t6_arvalid_async", ifu_arvalid, 1'b0);
    chk("t6_rready_async", ifu_rready, 1'b0);
    chk("t6_valid_async", ifu_to_idu_valid, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = RST_PC; xfer_m = 0; stall_m = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_stale_arvalid", ifu_arvalid, 1'b1);
      chk("t6_stale_araddr", ifu_araddr, RST_PC);
      chk("t6_stale_rready", ifu_rready, 1'b0);
      chk("t6_stale_valid", ifu_to_idu_valid, 1'b0);
      if (i == 2) slave_flush();
      model_step();
    end
    n = 0;
    while (xfer_m < 3 && n < 60) begin tick(1, 0, 0); n++; end
    chk("t6_three_xfers", 64'(xfer_m), 64'd3);
    tick(1, 0, 0);
`ifdef IFU_PERF_CNT_EN
    chk("t6_perf_fetch", perf_fetch_cnt, 32'd3);
    chk("t6_perf_stall", perf_stall_cnt, 32'(stall_b));
`endif

    // redirect in FETCH_R before the response: in-flight data is dropped
    rdly_max = 2;
    n = 0;
    while (!(ifu_rready && !ifu_rvalid) && n < 30) begin tick(1, 0, 0); n++; end
    chk("t3_reach_fetch_r", ifu_rready && !ifu_rvalid, 1'b1);
    tick(1, 1, 32'h8000_0100);
    n = 0;
    do begin tick(1, 0, 0); n++; end while (!ifu_arvalid && n < 30);
    chk("t3_drop_araddr", ifu_araddr, 32'h8000_0100);
    n = 0;
    while (!ifu_to_idu_valid && n < 30) begin tick(1, 0, 0); n++; end
    chk("t3_drop_bus_pc", ifu_to_idu_bus[63:32], 32'h8000_0100);

    // pc wrap past 2^32
    tick(1, 1, 32'hFFFF_FFFC);
    n = 0;
    do begin tick(1, 0, 0); n++; end while (!ifu_to_idu_valid && n < 30);
    chk("wrap_pc_top", ifu_to_idu_bus[63:32], 32'hFFFF_FFFC);
    n = 0;
    do begin tick(1, 0, 0); n++; end while (!ifu_to_idu_valid && n < 30);
    chk("wrap_pc_zero", ifu_to_idu_bus[63:32], 32'h0000_0000);

    // randomized traffic
    ar_rand = 1'b1; r_rand = 1'b1; rdly_max = 3; rand_err = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                        : (32'h8000_0000 | ($urandom & 32'h0000_0FFC));
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, tgt);
    end
    chk("rand_progress", 64'(xfer_m > 100), 64'd1);
    tick(1'b0, 1'b0, 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("rand_perf_fetch", perf_fetch_cnt, 32'(xfer_b));
    chk("rand_perf_stall", perf_stall_cnt, 32'(stall_b));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
